led_blink_monitor: RTL and testbench

// - Bench/in-system checker on the receiving end of the TestIC LED outputs: samples the two LED drive nets and

---
 rtl/led_mon_pkg.sv | 32 +++
 rtl/led_chan_monitor.sv | 165 ++++++++++++++++
 rtl/led_blink_monitor.sv | 82 ++++++++
 tb/tb_led_blink_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_mon_pkg
// Purpose  : Shared types and helpers for the LED blink monitor. Holds the
//            per-channel FSM state encoding and the window-bound helpers
//            that turn EXP_HALF/TOL into inclusive limits at elaboration.
// Revision : 1.0  initial release
// ============================================================================
package led_mon_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        MEAS = 3'd2,
        PASS = 3'd3,
        FAIL = 3'd4
    } state_t;

    // Lower window bound, clamped at zero so a tolerance wider than the
    // nominal half-period does not wrap around.
    function automatic int unsigned lo_bound(input int unsigned exp_half,
                                             input int unsigned tol);
        return (tol >= exp_half) ? 0 : (exp_half - tol);
    endfunction

    function automatic int unsigned hi_bound(input int unsigned exp_half,
                                             input int unsigned tol);
        return exp_half + tol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_chan_monitor.sv
`default_nettype none
// ============================================================================
// Module   : led_chan_monitor
// Purpose  : One LED channel: synchronizes the asynchronous LED net, detects
//            either edge, measures the clk count between edges and runs the
//            IDLE/ARM/MEAS/PASS/FAIL verdict machine.
// Ports    : clk, rst_n      clock, async active-low reset
//            en              1 = monitor, 0 = clear verdict and idle
//            led_in          asynchronous LED drive net
//            half[CNT_W]     last measured half-period
//            meas            1-cycle strobe, half just updated
//            pass, fail      registered verdicts (fail is sticky)
// Revision : 1.0  initial release
// ============================================================================
module led_chan_monitor
    import led_mon_pkg::*;
#(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned EXP_HALF  = 1000,
    parameter int unsigned TOL       = 16,
    parameter int unsigned MIN_EDGES = 4,
    parameter int unsigned TIMEOUT   = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             led_in,
    output logic [CNT_W-1:0] half,
    output logic             meas,
    output logic             pass,
    output logic             fail
);

    localparam int unsigned      LO_BOUND  = lo_bound(EXP_HALF, TOL);
    localparam int unsigned      HI_BOUND  = hi_bound(EXP_HALF, TOL);
    localparam logic [CNT_W-1:0] LO_C      = CNT_W'(LO_BOUND);
    localparam logic [CNT_W-1:0] HI_C      = CNT_W'(HI_BOUND);
    localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // good only needs to count up to MIN_EDGES-1; the MIN_EDGES-th good
    // measurement moves straight to PASS.
    localparam int unsigned      GOOD_W    = (MIN_EDGES < 2) ? 1 : $clog2(MIN_EDGES);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(MIN_EDGES - 1);

    state_t             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               s3_q, s3_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic               meas_q, meas_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;

    logic               edge_seen;
    logic               in_win;
    logic               timeout;

    assign edge_seen = s2_q ^ s3_q;
    assign in_win    = (cnt_q >= LO_C) && (cnt_q <= HI_C);
    assign timeout   = (cnt_q >= TMO_C);

    always_comb begin
        s1_d    = led_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        state_d = state_q;
        cnt_d   = edge_seen ? CNT_ONE
                : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        good_d  = good_q;
        half_d  = half_q;
        meas_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                good_d = '0;
                // Arming acts as the reference point for the stuck-LED
                // timeout, so the counter starts at 1 just like after an edge.
                if (en) begin
                    state_d = ARM;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM: begin
                // First edge only establishes a reference; nothing measured.
                if (edge_seen) begin
                    state_d = MEAS;
                end else if (timeout) begin
                    state_d = FAIL;
                end
            end
            MEAS, PASS, FAIL: begin
                // An edge on the timeout cycle still measures; the window
                // check then fails because TIMEOUT lies above the window.
                if (edge_seen) begin
                    half_d = cnt_q;
                    meas_d = 1'b1;
                    if (state_q != FAIL) begin
                        if (!in_win) begin
                            state_d = FAIL;
                        end else if (state_q == MEAS) begin
                            if (good_q == GOOD_LAST) begin
                                state_d = PASS;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end
                    end
                end else if (timeout && (state_q != FAIL)) begin
                    state_d = FAIL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable overrides any simultaneous edge or timeout.
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            good_d  = '0;
            meas_d  = 1'b0;
        end

        pass_d = (state_d == PASS);
        fail_d = (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            good_q  <= '0;
            half_q  <= '0;
            meas_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            half_q  <= half_d;
            meas_q  <= meas_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign half = half_q;
    assign meas = meas_q;
    assign pass = pass_q;
    assign fail = fail_q;

endmodule
`default_nettype wire

// File: rtl/led_blink_monitor.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_monitor
// Purpose  : Checks that two LED drive nets toggle with the expected
//            half-period of the oscillator clock; reports measured
//            half-periods and per-channel plus combined verdicts.
// Ports    : clk, rst_n            oscillator clock, async active-low reset
//            en                    1 = monitor, 0 = clear verdicts
//            led_a_in, led_b_in    asynchronous LED drive nets
//            half_a, half_b        last measured half-periods
//            meas_a, meas_b        1-cycle update strobes
//            pass_a/b, fail_a/b    per-channel verdicts (fail sticky)
//            pass, fail            combined verdicts
// Revision : 1.0  initial release
// ============================================================================
module led_blink_monitor
    import led_mon_pkg::*;
#(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned EXP_HALF  = 1000,
    parameter int unsigned TOL       = 16,
    parameter int unsigned MIN_EDGES = 4,
    parameter int unsigned TIMEOUT   = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             led_a_in,
    input  logic             led_b_in,
    output logic [CNT_W-1:0] half_a,
    output logic [CNT_W-1:0] half_b,
    output logic             meas_a,
    output logic             meas_b,
    output logic             pass_a,
    output logic             pass_b,
    output logic             fail_a,
    output logic             fail_b,
    output logic             pass,
    output logic             fail
);

    led_chan_monitor #(
        .CNT_W     (CNT_W),
        .EXP_HALF  (EXP_HALF),
        .TOL       (TOL),
        .MIN_EDGES (MIN_EDGES),
        .TIMEOUT   (TIMEOUT)
    ) u_chan_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .led_in (led_a_in),
        .half   (half_a),
        .meas   (meas_a),
        .pass   (pass_a),
        .fail   (fail_a)
    );

    led_chan_monitor #(
        .CNT_W     (CNT_W),
        .EXP_HALF  (EXP_HALF),
        .TOL       (TOL),
        .MIN_EDGES (MIN_EDGES),
        .TIMEOUT   (TIMEOUT)
    ) u_chan_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .led_in (led_b_in),
        .half   (half_b),
        .meas   (meas_b),
        .pass   (pass_b),
        .fail   (fail_b)
    );

    // Both inputs are flop outputs, so the combined verdicts change only on
    // clk edges together with the per-channel ones.
    assign pass = pass_a & pass_b & ~fail_a & ~fail_b;
    assign fail = fail_a | fail_b;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_monitor
// Purpose  : Self-checking bench for led_blink_monitor with EXP_HALF=100,
//            TOL=4 (window 96..104), MIN_EDGES=4, TIMEOUT=200, CNT_W=12.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_blink_monitor;

    localparam int CNT_W = 12;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             led_a;
    logic             led_b;
    logic [CNT_W-1:0] half_a, half_b;
    logic             meas_a, meas_b;
    logic             pass_a, pass_b, fail_a, fail_b;
    logic             pass, fail;

    int checks = 0;
    int errors = 0;
    int meas_cnt_a = 0;
    int meas_cnt_b = 0;

    led_blink_monitor #(
        .CNT_W     (CNT_W),
        .EXP_HALF  (100),
        .TOL       (4),
        .MIN_EDGES (4),
        .TIMEOUT   (200)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .led_a_in (led_a),
        .led_b_in (led_b),
        .half_a   (half_a),
        .half_b   (half_b),
        .meas_a   (meas_a),
        .meas_b   (meas_b),
        .pass_a   (pass_a),
        .pass_b   (pass_b),
        .fail_a   (fail_a),
        .fail_b   (fail_b),
        .pass     (pass),
        .fail     (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes once per cycle, shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (meas_a === 1'b1) meas_cnt_a++;
        if (meas_b === 1'b1) meas_cnt_b++;
    end

    typedef struct packed {
        logic [7:0][15:0] ia;     // toggle spacings for A, 0 terminates
        logic [7:0][15:0] ib;
        int               half_a;
        int               half_b;
        bit               pa;
        bit               fa;
        bit               pb;
        bit               fb;
        int               ma;     // expected meas_a strobes
        int               mb;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0][15:0] iv8(input int x0, input int x1, input int x2,
                                             input int x3, input int x4, input int x5,
                                             input int x6, input int x7);
        logic [7:0][15:0] r;
        r[0] = 16'(x0); r[1] = 16'(x1); r[2] = 16'(x2); r[3] = 16'(x3);
        r[4] = 16'(x4); r[5] = 16'(x5); r[6] = 16'(x6); r[7] = 16'(x7);
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0][15:0] ia, input logic [7:0][15:0] ib,
                                input int ha, input int hb, input bit pa, input bit fa,
                                input bit pb, input bit fb, input int ma, input int mb);
        vec_t v;
        v.ia = ia; v.ib = ib; v.half_a = ha; v.half_b = hb;
        v.pa = pa; v.fa = fa; v.pb = pb; v.fb = fb; v.ma = ma; v.mb = mb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        en    = 1'b0;
        led_a = 1'b0;
        led_b = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Toggle each LED after the listed number of cycles, one spacing after
    // another, then let the pipeline settle.
    task automatic drive(input logic [7:0][15:0] ia, input logic [7:0][15:0] ib);
        int ka = 0;
        int kb = 0;
        int ta = int'(ia[0]);
        int tb = int'(ib[0]);
        while ((ka < 8 && ia[ka] != 0) || (kb < 8 && ib[kb] != 0)) begin
            @(negedge clk);
            if (ka < 8 && ia[ka] != 0) begin
                ta--;
                if (ta == 0) begin
                    led_a = ~led_a;
                    ka++;
                    if (ka < 8) ta = int'(ia[ka]);
                end
            end
            if (kb < 8 && ib[kb] != 0) begin
                tb--;
                if (tb == 0) begin
                    led_b = ~led_b;
                    kb++;
                    if (kb < 8) tb = int'(ib[kb]);
                end
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input string tag);
        int base_a = meas_cnt_a;
        int base_b = meas_cnt_b;
        en = 1'b1;
        drive(v.ia, v.ib);
        check({tag, " half_a"}, 32'(half_a), v.half_a);
        check({tag, " half_b"}, 32'(half_b), v.half_b);
        check({tag, " pass_a"}, 32'(pass_a), 32'(v.pa));
        check({tag, " fail_a"}, 32'(fail_a), 32'(v.fa));
        check({tag, " pass_b"}, 32'(pass_b), 32'(v.pb));
        check({tag, " fail_b"}, 32'(fail_b), 32'(v.fb));
        check({tag, " pass"},   32'(pass), 32'(v.pa & v.pb & ~v.fa & ~v.fb));
        check({tag, " fail"},   32'(fail), 32'(v.fa | v.fb));
        check({tag, " meas_a count"}, meas_cnt_a - base_a, v.ma);
        check({tag, " meas_b count"}, meas_cnt_b - base_b, v.mb);
    endtask

    initial begin
        int base_a;
        int base_b;

        // {A spacings, B spacings, half_a, half_b, pa, fa, pb, fb, #meas_a, #meas_b}
        vecs[0] = mk(iv8(5,100,100,100,100,0,0,0), iv8(7,100,100,100,100,0,0,0),
                     100, 100, 1, 0, 1, 0, 4, 4);
        vecs[1] = mk(iv8(5,97,97,97,97,95,0,0),    iv8(5,100,100,100,100,0,0,0),
                     95, 100, 0, 1, 1, 0, 5, 4);
        vecs[2] = mk(iv8(5,96,104,96,104,0,0,0),   iv8(5,103,97,99,101,0,0,0),
                     104, 101, 1, 0, 1, 0, 4, 4);
        vecs[3] = mk(iv8(5,100,100,100,100,105,0,0), iv8(5,100,100,100,100,0,0,0),
                     105, 100, 0, 1, 1, 0, 5, 4);
        vecs[4] = mk(iv8(5,100,100,100,100,105,100,100), iv8(5,100,100,100,100,100,100,100),
                     100, 100, 0, 1, 1, 0, 7, 7);
        vecs[5] = mk(iv8(5,100,100,100,95,0,0,0),  iv8(5,100,100,100,100,100,0,0),
                     95, 100, 0, 1, 1, 0, 4, 5);
        vecs[6] = mk(iv8(5,100,200,0,0,0,0,0),     iv8(5,100,100,100,100,0,0,0),
                     200, 100, 0, 1, 1, 0, 2, 4);
        vecs[7] = mk(iv8(5,100,201,0,0,0,0,0),     iv8(5,100,100,100,100,0,0,0),
                     201, 100, 0, 1, 1, 0, 2, 4);

        // Reset state
        en = 1'b0; led_a = 1'b0; led_b = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset half_a", 32'(half_a), 0);
        check("reset half_b", 32'(half_b), 0);
        check("reset meas_a", 32'(meas_a), 0);
        check("reset meas_b", 32'(meas_b), 0);
        check("reset pass_a", 32'(pass_a), 0);
        check("reset pass_b", 32'(pass_b), 0);
        check("reset fail_a", 32'(fail_a), 0);
        check("reset fail_b", 32'(fail_b), 0);
        check("reset pass",   32'(pass), 0);
        check("reset fail",   32'(fail), 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Stuck LED B from the start; A toggles normally.
        do_reset();
        base_a = meas_cnt_a;
        base_b = meas_cnt_b;
        en = 1'b1;
        for (int k = 1; k <= 202; k++) begin
            @(negedge clk);
            if (k == 200) check("stuck fail_b before timeout", 32'(fail_b), 0);
            if (k == 201) begin
                check("stuck fail_b at timeout", 32'(fail_b), 1);
                check("stuck fail",   32'(fail), 1);
                check("stuck pass",   32'(pass), 0);
            end
            if (k == 202) begin
                check("stuck half_b", 32'(half_b), 0);
                check("stuck meas_b count", meas_cnt_b - base_b, 0);
                check("stuck fail_a", 32'(fail_a), 0);
                check("stuck half_a", 32'(half_a), 100);
                check("stuck meas_a count", meas_cnt_a - base_a, 1);
            end
            if (k == 5 || k == 105) led_a = ~led_a;
        end

        // Pass latency, one-cycle en drop, re-arm and re-pass.
        do_reset();
        en = 1'b1;
        base_a = meas_cnt_a;
        for (int k = 1; k <= 912; k++) begin
            @(negedge clk);
            if (k == 407) check("latency pass before 5th edge", 32'(pass), 0);
            if (k == 408) check("latency pass after 5th edge", 32'(pass), 1);
            if (k == 451) begin
                check("endrop pass",   32'(pass), 0);
                check("endrop pass_a", 32'(pass_a), 0);
                check("endrop pass_b", 32'(pass_b), 0);
                check("endrop fail",   32'(fail), 0);
                base_a = meas_cnt_a;
                en = 1'b1;
            end
            if (k == 515) check("rearm first edge meas_a", meas_cnt_a - base_a, 0);
            if (k == 912) begin
                check("rearm pass", 32'(pass), 1);
                check("rearm meas_a count", meas_cnt_a - base_a, 4);
                check("rearm half_a", 32'(half_a), 100);
            end
            if (k % 100 == 5) begin
                led_a = ~led_a;
                led_b = ~led_b;
            end
            if (k == 450) en = 1'b0;
        end

        // Asynchronous reset in the middle of MEAS, then a clean re-pass.
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (k % 100 == 5) begin
                led_a = ~led_a;
                led_b = ~led_b;
            end
        end
        check("premature half_a", 32'(half_a), 100);
        #2 rst_n = 1'b0;
        #1;
        check("async rst half_a", 32'(half_a), 0);
        check("async rst half_b", 32'(half_b), 0);
        check("async rst pass",   32'(pass), 0);
        check("async rst fail",   32'(fail), 0);
        en = 1'b0; led_a = 1'b0; led_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
